// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, flag bit positions and op classification for alu_pipe
package alu_pkg;
  typedef enum logic [3:0] {
    OP_PASSA, OP_SUB, OP_ADD, OP_ADD1, OP_ADDNB, OP_ADDNB1, OP_DEC, OP_PASSB,
    OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_ADC, OP_SBC
  } op_t;
  localparam int FLG_V = 0;
  localparam int FLG_C = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 3;
  function automatic logic is_arith(op_t op);
    return op inside {OP_SUB, OP_ADD, OP_ADD1, OP_ADDNB, OP_ADDNB1, OP_DEC, OP_ADC, OP_SBC};
  endfunction
endpackage

// File: rtl/alu_if.sv
// alu_if: operand-side and result-side valid/ready handshakes of alu_pipe
interface alu_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] a, b, y;
  logic [3:0] op, flags;
  modport slave (input in_valid, a, b, op, out_ready, output in_ready, out_valid, y, flags);
  modport master (output in_valid, a, b, op, out_ready, input in_ready, out_valid, y, flags);
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational datapath producing result and {N,Z,C,V} for one op
module alu_core
  import alu_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH-1:0] bb;
  logic [WIDTH:0] sum;
  logic ci, arith;
  // every arithmetic op is a + (b | ~b | all-ones) + carry-in
  always_comb begin
    bb = (op inside {OP_SUB, OP_ADDNB, OP_ADDNB1, OP_SBC}) ? ~b : (op == OP_DEC) ? '1 : b;
    ci = (op inside {OP_SUB, OP_ADD1, OP_ADDNB1}) ? 1'b1 : (op inside {OP_ADC, OP_SBC}) ? cin : 1'b0;
    sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
    arith = is_arith(op);
    case (op)
      OP_PASSA: y = a;
      OP_PASSB: y = b;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOT:   y = ~a;
      OP_SHL:   y = a << b[SHW-1:0];
      OP_SHR:   y = a >> b[SHW-1:0];
      default:  y = sum[WIDTH-1:0];
    endcase
    flags[FLG_N] = y[WIDTH-1];
    flags[FLG_Z] = ~|y;
    flags[FLG_C] = arith & sum[WIDTH];
    flags[FLG_V] = arith & (a[WIDTH-1] == bb[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with carry register and valid/ready on both sides
module alu_pipe
  import alu_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  io,
  output logic  carry_q
);
  logic [WIDTH-1:0] cy, s1_y;
  logic [3:0] cf, s1_f;
  logic s1_valid, accept, s2_load;
  op_t op;
  assign op = op_t'(io.op);
  alu_core #(.WIDTH(WIDTH)) u_core (.a(io.a), .b(io.b), .op(op), .cin(carry_q), .y(cy), .flags(cf));
  assign io.in_ready = !s1_valid || !io.out_valid || io.out_ready;
  assign accept = io.in_valid && io.in_ready;
  assign s2_load = s1_valid && (!io.out_valid || io.out_ready);
  // in_ready guarantees s1 is emptying whenever it is overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_y <= '0;
      s1_f <= '0;
      carry_q <= 1'b0;
      io.out_valid <= 1'b0;
      io.y <= '0;
      io.flags <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_y <= cy;
        s1_f <= cf;
        if (is_arith(op)) carry_q <= cf[FLG_C];
      end else if (s2_load) s1_valid <= 1'b0;
      if (s2_load) begin
        io.out_valid <= 1'b1;
        io.y <= s1_y;
        io.flags <= s1_f;
      end else if (io.out_ready) io.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random stimulus against a transaction-level ALU model
module tb_alu_pipe;
  typedef struct {logic [31:0] y; logic [3:0] f; int t;} exp_t;
  logic clk = 0;
  logic rst_n;
  logic carry_q;
  int checks = 0, failures = 0, cyc = 0, n_acc = 0;
  logic mc = 0, last_acc = 0;
  logic [31:0] ly = 0;
  logic [3:0] lf = 0;
  exp_t q[$];
  logic [31:0] got[$];
  alu_if #(.WIDTH(32)) intf ();
  alu_pipe #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .io(intf), .carry_q(carry_q));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic arith(input logic [3:0] o);
    return o inside {1, 2, 3, 4, 5, 6, 14, 15};
  endfunction

  // result = {y, N, Z, C, V}; overflow means the exact signed sum does not fit the result
  function automatic logic [35:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] z, input logic ci);
    logic [31:0] r, s;
    logic [63:0] u;
    longint sv;
    int k;
    logic c, v;
    s = (o inside {1, 4, 5, 15}) ? ~z : (o == 6) ? 32'hFFFF_FFFF : z;
    k = (o inside {1, 3, 5}) ? 1 : (o inside {14, 15}) ? int'(ci) : 0;
    u = 64'(x) + 64'(s) + 64'(k);
    sv = longint'($signed(x)) + longint'($signed(s)) + longint'(k);
    case (o)
      0: r = x;
      7: r = z;
      8: r = x & z;
      9: r = x | z;
      10: r = x ^ z;
      11: r = ~x;
      12: r = x << z[4:0];
      13: r = x >> z[4:0];
      default: r = u[31:0];
    endcase
    c = arith(o) ? u[32] : 1'b0;
    v = arith(o) ? (sv != longint'($signed(r))) : 1'b0;
    return {r, r[31], r == 32'd0, c, v};
  endfunction

  task automatic step(input logic v, input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb, input logic ordy);
    logic acc, xfer;
    logic [35:0] e;
    intf.in_valid = v;
    intf.op = o;
    intf.a = aa;
    intf.b = bb;
    intf.out_ready = ordy;
    #1;
    chk("out_valid", 64'(intf.out_valid), 64'((q.size() > 0) && (cyc >= q[0].t + 1)));
    if (intf.out_valid && q.size() > 0) begin
      chk("y", 64'(intf.y), 64'(q[0].y));
      chk("flags", 64'(intf.flags), 64'(q[0].f));
    end
    chk("in_ready", 64'(intf.in_ready), 64'(!(q.size() == 2 && !ordy)));
    chk("carry_q", 64'(carry_q), 64'(mc));
    acc = v && intf.in_ready;
    xfer = intf.out_valid && ordy;
    if (xfer) begin
      ly = intf.y;
      lf = intf.flags;
      got.push_back(intf.y);
    end
    @(posedge clk);
    cyc++;
    if (xfer && q.size() > 0) void'(q.pop_front());
    if (acc) begin
      e = model(o, aa, bb, mc);
      q.push_back('{e[35:4], e[3:0], cyc});
      if (arith(o)) mc = e[1];
    end
    last_acc = acc;
    n_acc += int'(acc);
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb, input logic ordy);
    last_acc = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, o, aa, bb, ordy);
      if (last_acc) break;
    end
    chk("send_timeout", 64'(last_acc), 64'(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] c[4] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    return ($urandom_range(3) == 0) ? c[$urandom_range(3)] : $urandom();
  endfunction

  initial begin
    rst_n = 0;
    intf.in_valid = 0;
    intf.a = 0;
    intf.b = 0;
    intf.op = 0;
    intf.out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(intf.out_valid), 64'(0));
    chk("rst_y", 64'(intf.y), 64'(0));
    chk("rst_flags", 64'(intf.flags), 64'(0));
    chk("rst_carry", 64'(carry_q), 64'(0));
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", 64'(intf.in_ready), 64'(1));
    // wrap-around add, two-cycle latency
    send(2, 32'hFFFF_FFFF, 32'd1, 1);
    chk("lat_t1", 64'(intf.out_valid), 64'(0));
    step(0, 0, 0, 0, 1);
    chk("lat_t2", 64'(intf.out_valid), 64'(1));
    idle(2);
    chk("t1_y", 64'(ly), 64'(0));
    chk("t1_flags", 64'(lf), 64'(4'b0110));
    chk("t1_carry", 64'(carry_q), 64'(1));
    // back-to-back add-with-carry
    got.delete();
    send(2, 32'hFFFF_FFFF, 32'd1, 1);
    send(14, 32'd5, 32'd6, 1);
    send(14, 32'd5, 32'd6, 1);
    idle(4);
    chk("adc_n", 64'(got.size()), 64'(3));
    chk("adc_y1", 64'(got[1]), 64'(12));
    chk("adc_y2", 64'(got[2]), 64'(11));
    chk("adc_flags", 64'(lf), 64'(4'b0000));
    // signed overflow, then borrow
    send(2, 32'h7FFF_FFFF, 32'd1, 1);
    idle(3);
    chk("ovf_y", 64'(ly), 64'(32'h8000_0000));
    chk("ovf_flags", 64'(lf), 64'(4'b1001));
    send(1, 32'd3, 32'd5, 1);
    idle(3);
    chk("sub_y", 64'(ly), 64'(32'hFFFF_FFFE));
    chk("sub_flags", 64'(lf), 64'(4'b1000));
    // backpressure: two results held, then in_ready drops
    got.delete();
    n_acc = 0;
    send(0, 32'd1, 0, 0);
    send(0, 32'd2, 0, 0);
    repeat (4) step(1, 0, 32'd3, 0, 0);
    chk("bp_accepts", 64'(n_acc), 64'(2));
    chk("bp_in_ready", 64'(intf.in_ready), 64'(0));
    chk("bp_y_held", 64'(intf.y), 64'(1));
    send(0, 32'd3, 0, 1);
    send(0, 32'd4, 0, 1);
    idle(4);
    chk("bp_n", 64'(got.size()), 64'(4));
    for (int i = 0; i < 4; i++) chk("bp_order", 64'(got[i]), 64'(i + 1));
    // shifts and logic leave the carry alone
    got.delete();
    send(3, 32'hFFFF_FFFF, 0, 1);
    send(12, 32'd1, 32'hFFFF_FFE3, 1);
    send(13, 32'h8000_0000, 32'd31, 1);
    send(11, 0, 0, 1);
    idle(4);
    chk("shl_y", 64'(got[1]), 64'(8));
    chk("shr_y", 64'(got[2]), 64'(1));
    chk("not_y", 64'(got[3]), 64'(32'hFFFF_FFFF));
    chk("not_flags", 64'(lf), 64'(4'b1000));
    chk("logic_carry", 64'(carry_q), 64'(1));
    // random traffic with random backpressure
    for (int i = 0; i < 600; i++)
      step($urandom_range(3) != 0, 4'($urandom_range(15)), pick(), pick(), $urandom_range(9) < 7);
    idle(4);
    // reset with two results pending and carry set
    send(2, 32'hFFFF_FFFF, 32'd1, 1);
    idle(3);
    send(0, 32'd7, 0, 0);
    send(0, 32'd8, 0, 0);
    chk("pre_rst_valid", 64'(intf.out_valid), 64'(1));
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 64'(intf.out_valid), 64'(0));
    chk("mid_rst_y", 64'(intf.y), 64'(0));
    chk("mid_rst_carry", 64'(carry_q), 64'(0));
    intf.in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    q.delete();
    mc = 0;
    cyc = 0;
    @(negedge clk);
    send(14, 32'd1, 32'd1, 1);
    idle(3);
    chk("post_rst_y", 64'(ly), 64'(2));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the team's 32-bit combinational arithmetic unit.
- Keeps the original eight arithmetic/pass operations at the same encodings and adds:
  - logic operations and shifts;
  - add-with-carry and subtract-with-carry driven by an internal carry register;
  - Z/N/C/V flags;
  - valid/ready handshakes on both sides.
- Sits between the operand/decode logic and the result writeback path; backpressure from writeback stalls the pipeline without losing data.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 4).
- SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0]. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op are presented.
- in_ready  output  1  block accepts this cycle. Transfer occurs when in_valid && in_ready.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  4  operation select (encodings below).
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  downstream accepts. Transfer occurs when out_valid && out_ready.
- y  output  WIDTH  result.
- flags  output  4  {N,Z,C,V} belonging to y.
- carry_q  output  1  current internal carry register (debug/visibility).

Behaviour:
- Reset (async assert, sync release): out_valid=0, y=0, flags=0, carry_q=0, both stage-valid bits=0, in_ready=1 after release. Reset mid-operation discards all in-flight results.
- Op encodings. All arithmetic is modulo 2^WIDTH, with carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 0 y=a
  - 1 y=a-b (computed as a+~b+1)
  - 2 a+b
  - 3 a+b+1
  - 4 a+~b
  - 5 a+~b+1
  - 6 a-1 (computed as a+all-ones)
  - 7 y=b
  - 8 a&b
  - 9 a|b
  - 10 a^b
  - 11 ~a
  - 12 a<<b[SHW-1:0]
  - 13 a>>b[SHW-1:0] (logical)
  - 14 a+b+carry_q
  - 15 a+~b+carry_q
- Flags:
  - N = y[WIDTH-1] and Z = (y==0), for every op.
  - C = carry-out and V = signed overflow (operand signs equal, result sign differs; for ops 1,4,5,15 the second operand is ~b) for arithmetic ops 1-6,14,15.
  - For ops 0,7-13, C and V are reported as 0.
- Carry register: on each accepted transaction with an arithmetic op, carry_q <= that op's C. Non-arithmetic ops leave carry_q unchanged. Updated in the same cycle the transaction is accepted, in order, so a back-to-back op 14/15 uses the carry of the immediately preceding accepted arithmetic op.
- Pipeline:
  - Stage 1 registers the computed result and flags at accept.
  - Stage 2 is the output register.
  - Latency: accept in cycle T gives out_valid in T+2 if not stalled. Throughput is 1 per cycle.
- Stall rules:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - Stage 1 captures when in_valid && in_ready.
  - in_ready = !s1_valid || !out_valid || out_ready (combinational from out_ready).
  - out_valid clears when a transfer occurs and s1 is empty.
  - With out_ready=0 the block holds exactly 2 results, then deasserts in_ready.
  - y/flags remain stable while out_valid && !out_ready.
- Simultaneous out transfer and new accept in the same cycle is legal and loses nothing.
- Ops 12/13: shift amounts >= WIDTH cannot occur (SHW bits); upper b bits are ignored.

Decomposition:
- Package alu_pkg holds:
  - the op_t enum (the 16 encodings above);
  - flag bit index constants (FLG_V=0, FLG_C=1, FLG_Z=2, FLG_N=3);
  - an is_arith(op) function.
- One combinational sub-module, alu_core: a, b, op, cin → y, flags. It contains all datapath logic. alu_pipe contains only the carry register, the two pipeline stages and the handshake.

Test Plan:
- After reset with out_ready=1, op=2, a=32'hFFFF_FFFF, b=1 → two cycles later y=0, flags N0 Z1 C1 V0; carry_q=1.
- Back-to-back: op=2 a=32'hFFFF_FFFF b=1, then op=14 a=5 b=6 → second result y=12 (carry used), C=0; then op=14 a=5 b=6 again → y=11.
- Signed overflow: op=2 a=32'h7FFF_FFFF b=1 → y=32'h8000_0000, N1 V1 C0. Then op=1 a=3 b=5 → y=32'hFFFF_FFFE, C0 (borrow), N1.
- Backpressure: hold out_ready=0 and stream 4 ops (op=0, a=1..4) → in_ready drops after 2 accepts. Release out_ready → outputs 1,2,3,4 in order, none lost or duplicated, y stable while stalled.
- Shifts/logic: op=12 a=1 b=32'hFFFF_FFE3 → y=8 (amount 3); op=13 a=32'h8000_0000 b=31 → y=1; op=11 a=0 → y=32'hFFFF_FFFF, C0 V0; carry_q unchanged across these.
- Reset mid-stream with 2 results pending and carry_q=1 → out_valid=0, y=0, carry_q=0 immediately; the first op after release (op=14 a=1 b=1) gives y=2.
